// File: rtl/bmm_pkg.sv
// Shared block-matrix-multiply package: tile geometry defaults, packed word
// width and the pack-stage state encoding.
// Imported by matrix_pack and by matrix_fill so that both sides agree on layout.
package bmm_pkg;

  // Tile geometry defaults: ROWS x COLS elements of EW bits each.
  localparam int BMM_ROWS   = 2;
  localparam int BMM_COLS   = 4;
  localparam int BMM_EW     = 4;
  // Packed tile width. Element (i,j) lives at [(i*COLS+j)*EW +: EW].
  localparam int BMM_WORD_W = BMM_ROWS * BMM_COLS * BMM_EW;

  // Pack-stage states. FILL accepts elements; FULL holds a closed tile while
  // the output register is still occupied.
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_FULL = 1'b1
  } pack_state_e;

endpackage

// File: rtl/matrix_pack.sv
// Packs a row-major element stream into one ROWS*COLS*EW tile word (A_rows layout).
// Latency: out_valid rises one cycle after the closing element is accepted.
// Backpressure: a closed tile waits in FULL (in_ready=0) until the output
// register frees; with out_ready=1 it streams one element/cycle with no bubbles.
// Ports: clk, rst_n (async active-low); in_data/in_valid/in_last/in_ready
// element stream in; out_data/out_valid/out_ready/out_partial tile word out.
module matrix_pack
  import bmm_pkg::*;
#(
  parameter int ROWS = BMM_ROWS,
  parameter int COLS = BMM_COLS,
  parameter int EW   = BMM_EW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [EW-1:0]            in_data,
  input  logic                     in_valid,
  input  logic                     in_last,
  output logic                     in_ready,
  output logic [ROWS*COLS*EW-1:0]  out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_partial
);

  localparam int N  = ROWS * COLS;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int W  = N * EW;
  localparam logic [KW-1:0] K_LAST = KW'(N - 1);

  pack_state_e   state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [W-1:0]  asm_q, asm_d;
  logic          held_partial_q, held_partial_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_partial_q, out_partial_d;

  logic [W-1:0]  asm_wr;
  logic          at_last_slot;
  logic          out_free;

  assign in_ready    = (state_q == ST_FILL);
  assign out_data    = out_data_q;
  assign out_valid   = out_valid_q;
  assign out_partial = out_partial_q;

  always_comb begin
    state_d        = state_q;
    k_d            = k_q;
    asm_d          = asm_q;
    held_partial_d = held_partial_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    out_partial_d  = out_partial_q;

    // Assembly word with the incoming element dropped into slot k.
    asm_wr = asm_q;
    asm_wr[k_q*EW +: EW] = in_data;

    at_last_slot = (k_q == K_LAST);
    // Output register can take a new word this edge if empty or being drained.
    out_free = !out_valid_q || out_ready;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_FILL: begin
        if (in_valid) begin
          if (at_last_slot || in_last) begin
            if (out_free) begin
              out_data_d    = asm_wr;
              out_valid_d   = 1'b1;
              out_partial_d = !at_last_slot;
              asm_d         = '0;
              k_d           = '0;
            end else begin
              // Park the closed tile; partial flag travels with it.
              asm_d          = asm_wr;
              held_partial_d = !at_last_slot;
              state_d        = ST_FULL;
            end
          end else begin
            asm_d = asm_wr;
            k_d   = k_q + 1'b1;
          end
        end
      end
      ST_FULL: begin
        // out_valid is necessarily 1 here, so out_ready alone frees the register.
        if (out_ready) begin
          out_data_d    = asm_q;
          out_valid_d   = 1'b1;
          out_partial_d = held_partial_q;
          asm_d         = '0;
          k_d           = '0;
          state_d       = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_FILL;
      k_q            <= '0;
      asm_q          <= '0;
      held_partial_q <= 1'b0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      out_partial_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      k_q            <= k_d;
      asm_q          <= asm_d;
      held_partial_q <= held_partial_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      out_partial_q  <= out_partial_d;
    end
  end

endmodule

// File: tb/tb_matrix_pack.sv
// Directed bench for matrix_pack: reset, full/partial tiles, back-to-back
// streaming, output backpressure, mid-tile reset and random unpack loopback.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_matrix_pack;

  logic        clk;
  logic        rst_n;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_partial;

  int checks   = 0;
  int failures = 0;

  matrix_pack #(.ROWS(2), .COLS(4), .EW(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_partial(out_partial)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Present one element for exactly one rising edge.
  task automatic send(input logic [3:0] d, input logic last);
    in_data  = d;
    in_valid = 1'b1;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  logic [3:0]  elems [8];
  logic [31:0] word;

  initial begin
    rst_n     = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset values.
    #2;
    chk("rst_out_valid",   {31'd0, out_valid},   32'd0);
    chk("rst_out_data",    out_data,             32'd0);
    chk("rst_out_partial", {31'd0, out_partial}, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Full tile 1..8 with in_last on the 8th element.
    out_ready = 1'b1;
    for (int e = 1; e <= 7; e++) send(4'(e), 1'b0);
    chk("full_no_early_valid", {31'd0, out_valid}, 32'd0);
    send(4'd8, 1'b1);
    chk("full_out_valid",   {31'd0, out_valid},   32'd1);
    chk("full_out_data",    out_data,             32'h8765_4321);
    chk("full_out_partial", {31'd0, out_partial}, 32'd0);
    tick();
    chk("full_drained", {31'd0, out_valid}, 32'd0);

    // Early close after three elements: unwritten slots zero, partial set.
    send(4'hA, 1'b0);
    send(4'hB, 1'b0);
    send(4'hC, 1'b1);
    chk("part_out_valid",   {31'd0, out_valid},   32'd1);
    chk("part_out_data",    out_data,             32'h0000_0CBA);
    chk("part_out_partial", {31'd0, out_partial}, 32'd1);
    tick();

    // in_last on the first element; stale slots from the previous tile must be gone.
    send(4'h7, 1'b1);
    chk("single_out_data",    out_data,             32'h0000_0007);
    chk("single_out_partial", {31'd0, out_partial}, 32'd1);
    tick();
    chk("single_drained", {31'd0, out_valid}, 32'd0);

    // Back-to-back tiles 1..8 then 8..1 with no idle cycle.
    for (int e = 0; e < 16; e++) begin
      chk("b2b_in_ready", {31'd0, in_ready}, 32'd1);
      send((e < 8) ? 4'(e + 1) : 4'(16 - e), (e == 7) || (e == 15));
      if (e == 7)  chk("b2b_word0", out_data, 32'h8765_4321);
      if (e == 15) chk("b2b_word1", out_data, 32'h1234_5678);
    end
    chk("b2b_word1_partial", {31'd0, out_partial}, 32'd0);
    tick();

    // Output stalled: two full tiles, second parks in FULL.
    out_ready = 1'b0;
    for (int e = 1; e <= 8; e++) send(4'(e), 1'b0);
    chk("stall_word0_valid", {31'd0, out_valid}, 32'd1);
    for (int e = 9; e <= 16; e++) begin
      send(4'(e), 1'b0);
      if (e == 12) chk("stall_word0_stable", out_data, 32'h8765_4321);
    end
    chk("stall_in_ready_low", {31'd0, in_ready}, 32'd0);
    chk("stall_word0_held",   out_data,          32'h8765_4321);
    in_data  = 4'h5;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("stall_ignored_data", out_data,             32'h8765_4321);
    chk("stall_partial_held", {31'd0, out_partial}, 32'd0);
    chk("stall_still_full",   {31'd0, in_ready},    32'd0);
    out_ready = 1'b1;
    tick();
    chk("stall_word1_data",  out_data,          32'h0FED_CBA9);
    chk("stall_word1_valid", {31'd0, out_valid}, 32'd1);
    chk("stall_in_ready_up", {31'd0, in_ready},  32'd1);
    tick();
    chk("stall_drained", {31'd0, out_valid}, 32'd0);

    // Random tiles unpacked as A[i][j] = out_data[(i*4+j)*4 +: 4].
    for (int t = 0; t < 3; t++) begin
      for (int s = 0; s < 8; s++) elems[s] = 4'($urandom_range(0, 15));
      for (int s = 0; s < 8; s++) send(elems[s], s == 7);
      word = out_data;
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 4; j++)
          chk("loop_elem", {28'd0, word[(i*4+j)*4 +: 4]}, {28'd0, elems[i*4+j]});
      tick();
    end

    // Reset with a held word and a half-built tile: everything discarded.
    out_ready = 1'b0;
    for (int e = 0; e < 8; e++) send(4'h3, 1'b0);
    for (int e = 1; e <= 5; e++) send(4'(e), 1'b0);
    chk("prerst_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid",   {31'd0, out_valid},   32'd0);
    chk("midrst_out_data",    out_data,             32'd0);
    chk("midrst_out_partial", {31'd0, out_partial}, 32'd0);
    chk("midrst_in_ready",    {31'd0, in_ready},    32'd1);
    tick();
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int e = 0; e < 7; e++) send(4'hF, 1'b0);
    chk("postrst_no_stale", {31'd0, out_valid}, 32'd0);
    send(4'hF, 1'b0);
    chk("postrst_valid",   {31'd0, out_valid},   32'd1);
    chk("postrst_data",    out_data,             32'hFFFF_FFFF);
    chk("postrst_partial", {31'd0, out_partial}, 32'd0);
    tick();
    chk("postrst_one_word", {31'd0, out_valid}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_pack.md
MATRIX_PACK -- requirements
Module: matrix_pack

Interface
REQ-001 SHALL have parameter ROWS, default 2, matrix rows per tile.
REQ-002 SHALL have parameter COLS, default 4, matrix columns per tile.
REQ-003 SHALL have parameter EW, default 4, element width in bits.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port in_data  input  EW  one matrix element, row-major order.
REQ-007 SHALL have port in_valid  input  1  in_data valid.
REQ-008 SHALL have port in_last  input  1  marks the final element of a tile; qualified by in_valid.
REQ-009 SHALL have port in_ready  output  1  element accepted when in_valid && in_ready.
REQ-010 SHALL have port out_data  output  ROWS*COLS*EW  packed tile (A_rows layout).
REQ-011 SHALL have port out_valid  output  1  out_data valid.
REQ-012 SHALL have port out_ready  input  1  word consumed when out_valid && out_ready.
REQ-013 SHALL have port out_partial  output  1  tile was closed by in_last before ROWS*COLS elements.

Function
REQ-014 SHALL place accepted element number k (k = i*COLS + j, 0-based) at out_data bits [k*EW +: EW], i.e. element (i,j) at [(i*COLS+j)*EW +: EW], the exact inverse of the unpacking used by the fill stage.
REQ-015 SHALL hold an assembly register and write pointer k, range 0..ROWS*COLS-1, with states FILL and FULL.
REQ-016 FILL: each accepted element writes slot k; k increments; tile closes on k = ROWS*COLS-1 or in_last, whichever comes first.
REQ-017 On close, the assembled word SHALL transfer to the output register on the same edge if out_valid=0 or out_ready=1; otherwise the state SHALL go to FULL.
REQ-018 FULL: in_ready=0; the word SHALL transfer on the first edge with out_ready=1, then return to FILL with k=0.
REQ-019 in_ready SHALL be 1 in FILL and 0 in FULL, combinationally independent of in_valid.
REQ-020 Unwritten slots of a tile closed early by in_last SHALL be zero, and out_partial SHALL be 1 with that word.
REQ-021 in_last on the ROWS*COLS-th element SHALL close normally with out_partial=0; in_last on element 1 SHALL emit a word with only slot 0 populated.
REQ-022 Latency: out_valid SHALL assert one cycle after the closing element is accepted, when the output register is free.
REQ-023 out_data and out_partial SHALL hold stable while out_valid=1 and out_ready=0.
REQ-024 With out_ready held at 1, sustained throughput SHALL be one element per cycle with no bubble between tiles.
REQ-025 The assembly register SHALL be cleared to zero on each transfer to the output register.

Reset
REQ-026 rst_n low SHALL asynchronously force state FILL, k=0, assembly register 0, out_data 0, out_valid 0, out_partial 0.
REQ-027 After reset release, in_ready SHALL be 1 in the first cycle.
REQ-028 Reset mid-tile or with out_valid=1 SHALL discard all held data with no word emitted.

Structure
REQ-029 ROWS, COLS, EW defaults and the packed word width SHALL come from the shared bmm package used by matrix_fill.
REQ-030 The block SHALL be flat; no sub-module is required.

Verification
REQ-031 Feed 1..8, in_last on 8th, out_ready=1 -> out_data=0x87654321, out_partial=0, out_valid one cycle after the 8th element.
REQ-032 Feed 0xA,0xB,0xC with in_last on 0xC -> out_data=0x00000CBA, out_partial=1.
REQ-033 Hold out_ready=0; send two full tiles -> first word held stable, in_ready=0 after 16th element; raise out_ready -> words emitted in order, in_ready=1 again.
REQ-034 Back-to-back tiles 1..8 then 8..1, out_ready=1 -> 0x87654321 then 0x12345678; in_ready never low.
REQ-035 Assert rst_n=0 after 5 elements -> all outputs 0 immediately; next 8 elements 0xF each -> 0xFFFFFFFF only.
REQ-036 Loopback out_data into matrix_fill -> A[i][j] equals the (i*4+j)-th input element for random tiles.
